// File: rtl/mux_arbiter10.sv
// -----------------------------------------------------------------------------
// mux_arbiter10
//
// Round-robin arbiter for ten requesters feeding a downstream 10:1 mux.
// A grant is held until the owner signals DONE, drops its request, or the
// grant reaches MAX_HOLD cycles (forced release, flagged by a TIMEOUT pulse).
// Every release is followed by at least one idle cycle before the next grant.
//
// Parameters
//   MAX_HOLD  maximum grant length in cycles (legal 2..255)
//
// Ports
//   CLK      in   1   clock, all state changes on the rising edge
//   RST      in   1   synchronous active-high reset
//   REQ      in  10   request per requester, bit k = requester k
//   DONE     in   1   current owner finished (ignored while idle)
//   GNT      out 10   one-hot grant, all zero while idle
//   SEL      out  4   mux select code 0..9, holds last owner while idle
//   BUSY     out  1   high while a grant is active
//   TIMEOUT  out  1   one-cycle pulse in the idle cycle after a forced release
// -----------------------------------------------------------------------------
module mux_arbiter10 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] REQ,
  input  logic       DONE,
  output logic [9:0] GNT,
  output logic [3:0] SEL,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Hold counter value seen in the last permitted cycle of a grant.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r;
  logic [3:0] ptr_r;
  logic [7:0] hold_r;
  logic [9:0] gnt_r;
  logic [3:0] sel_r;
  logic       busy_r;
  logic       timeout_r;

  logic       found_s;
  logic [3:0] pick_s;
  logic       lost_s;
  logic       limit_s;
  logic       release_s;
  logic       forced_s;

  // Advance a requester index by one, wrapping 9 back to 0.
  function automatic logic [3:0] next_idx(input logic [3:0] idx);
    return (idx == 4'd9) ? 4'd0 : (idx + 4'd1);
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [9:0] onehot10(input logic [3:0] idx);
    return 10'b00_0000_0001 << idx;
  endfunction

  // Round-robin pick: scan from the pointer downward in priority order.
  // The scan runs from lowest priority to highest so the last hit wins.
  always_comb begin
    logic [4:0] sum_v;
    logic [3:0] idx_v;
    found_s = |REQ;
    pick_s  = 4'd0;
    sum_v   = 5'd0;
    idx_v   = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      sum_v  = {1'b0, ptr_r} + 5'(i);
      idx_v  = (sum_v >= 5'd10) ? 4'(sum_v - 5'd10) : sum_v[3:0];
      pick_s = REQ[idx_v] ? idx_v : pick_s;
    end
  end

  // Release decision for the current owner; forced only when the counter
  // limit is the sole reason (a coincident DONE or dropped request wins).
  always_comb begin
    lost_s    = ~|(REQ & gnt_r);
    limit_s   = (hold_r == HOLD_LAST);
    release_s = DONE | lost_s | limit_s;
    forced_s  = limit_s & ~DONE & ~lost_s;
  end

  // Arbiter state machine with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 4'd0;
      hold_r    <= 8'd0;
      gnt_r     <= 10'd0;
      sel_r     <= 4'd0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // The timeout pulse lives for exactly this one idle cycle.
          timeout_r <= 1'b0;
          if (found_s) begin
            state_r <= ST_OWN;
            gnt_r   <= onehot10(pick_s);
            sel_r   <= pick_s;
            busy_r  <= 1'b1;
            hold_r  <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (release_s) begin
            // Returning to idle gives break-before-make for free: no grant
            // can be issued at this edge.
            state_r   <= ST_IDLE;
            gnt_r     <= 10'd0;
            busy_r    <= 1'b0;
            ptr_r     <= next_idx(sel_r);
            timeout_r <= forced_s;
          end else begin
            hold_r <= hold_r + 8'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          gnt_r     <= 10'd0;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = gnt_r;
  assign SEL     = sel_r;
  assign BUSY    = busy_r;
  assign TIMEOUT = timeout_r;

endmodule

// File: tb/tb_mux_arbiter10.sv
// Self-checking bench for mux_arbiter10: directed scenarios plus random
// traffic, a grant-level reference model feeding a scoreboard queue, and a
// monitor that reconstructs grants from the DUT outputs and compares them.
module tb_mux_arbiter10;

  localparam int MH = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] REQ;
  logic       DONE;
  logic [9:0] GNT;
  logic [3:0] SEL;
  logic       BUSY;
  logic       TIMEOUT;

  mux_arbiter10 #(.MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
    .GNT(GNT), .SEL(SEL), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // One completed grant: owner, length in cycles, timeout flag, cut by reset.
  typedef struct {
    int idx;
    int len;
    bit tmo;
    bit rst;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: owner (-1 = idle), priority pointer, grant length.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_len   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic model_step(input logic [9:0] r, input logic d, input logic rs);
    if (rs) begin
      if (m_owner >= 0) exp_q.push_back('{m_owner, m_len, 1'b0, 1'b1});
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (r != 10'd0) begin
        for (int i = 0; i < 10; i++) begin
          int c;
          c = (m_ptr + i) % 10;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_len = 1;
      end
    end else begin
      bit lim;
      bit rel;
      lim = (m_len == MH);
      rel = d || !r[m_owner] || lim;
      if (rel) begin
        exp_q.push_back('{m_owner, m_len, lim && !d && r[m_owner], 1'b0});
        m_ptr   = (m_owner + 1) % 10;
        m_owner = -1;
      end else begin
        m_len++;
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge and step the model.
  task automatic cyc(input logic [9:0] r, input logic d, input logic rs);
    @(negedge CLK);
    REQ  = r;
    DONE = d;
    RST  = rs;
    model_step(r, d, rs);
  endtask

  task automatic check_reset_state();
    @(posedge CLK);
    #1;
    check("rst_gnt", GNT, 0);
    check("rst_sel", SEL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_timeout", TIMEOUT, 0);
  endtask

  // Monitor: rebuild grants from outputs, compare against the scoreboard.
  logic       mon_en = 1'b0;
  logic       prev_busy = 1'b0;
  int         cur_len = 0;
  logic [3:0] cur_sel = 4'd0;

  always @(negedge CLK) begin
    if (mon_en) begin
      check("busy_eq_or_gnt", BUSY, |GNT);
      check("sel_range", (SEL <= 4'd9), 1);
      if (BUSY) begin
        if (!prev_busy) begin
          cur_len = 1;
          cur_sel = SEL;
        end else begin
          cur_len++;
          check("sel_stable", SEL, cur_sel);
        end
        check("gnt_onehot_sel", GNT, 32'd1 << SEL);
        check("timeout_busy", TIMEOUT, 0);
      end else begin
        if (prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got idx %0d len %0d expected no grant", cur_sel, cur_len);
          end else begin
            rec_t e;
            e = exp_q.pop_front();
            check("grant_idx", cur_sel, e.idx);
            check("grant_len", cur_len, e.len);
            check("timeout_pulse", TIMEOUT, e.tmo);
            check("idle_sel", SEL, e.rst ? 0 : e.idx);
          end
        end else begin
          check("timeout_idle", TIMEOUT, 0);
        end
        check("gnt_idle", GNT, 0);
      end
      prev_busy = BUSY;
    end
  end

  initial begin
    REQ  = 10'd0;
    DONE = 1'b0;
    RST  = 1'b1;
    cyc(10'h000, 1'b0, 1'b1);
    cyc(10'h000, 1'b0, 1'b1);
    check_reset_state();
    mon_en = 1'b1;

    // Single requester, DONE in the third owned cycle.
    cyc(10'h004, 1'b0, 1'b0);
    cyc(10'h004, 1'b0, 1'b0);
    cyc(10'h004, 1'b0, 1'b0);
    cyc(10'h004, 1'b1, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);

    // Full load from a fresh pointer.
    cyc(10'h000, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) cyc(10'h3FF, 1'b1, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);

    // Timeout with a single held request, then re-grant.
    cyc(10'h000, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) cyc(10'h020, 1'b0, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);

    // Wrap-around: grant 8, then 9, then 0.
    cyc(10'h000, 1'b0, 1'b1);
    cyc(10'h100, 1'b0, 1'b0);
    cyc(10'h100, 1'b1, 1'b0);
    cyc(10'h201, 1'b0, 1'b0);
    cyc(10'h201, 1'b1, 1'b0);
    cyc(10'h201, 1'b0, 1'b0);
    cyc(10'h201, 1'b1, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);

    // Reset mid-grant, then pointer restarts at 0.
    cyc(10'h080, 1'b0, 1'b0);
    cyc(10'h080, 1'b0, 1'b0);
    cyc(10'h080, 1'b0, 1'b1);
    check_reset_state();
    cyc(10'h088, 1'b0, 1'b0);
    cyc(10'h088, 1'b1, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);

    // DONE coincides with the hold limit: normal release.
    cyc(10'h000, 1'b0, 1'b1);
    cyc(10'h020, 1'b0, 1'b0);
    for (int i = 0; i < MH - 1; i++) cyc(10'h020, 1'b0, 1'b0);
    cyc(10'h020, 1'b1, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);

    // Random traffic: sparse requests that change occasionally.
    begin
      logic [9:0] r;
      r = 10'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) r = 10'($urandom) & 10'($urandom);
        cyc(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0));
      end
    end

    cyc(10'h000, 1'b0, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);
    cyc(10'h000, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter10.md
MUX_ARBITER10 -- requirements
Module: mux_arbiter10

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 16, max grant length in cycles (legal 2..255).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: REQ  input  10  request per requester; index k = requester k.
REQ-005 SHALL have port: DONE  input  1  current owner finished; ignored when no grant active.
REQ-006 SHALL have port: GNT  output  10  one-hot grant, all zero when idle.
REQ-007 SHALL have port: SEL  output  4  select code for the downstream 10:1 mux, range 0..9.
REQ-008 SHALL have port: BUSY  output  1  high while any grant is active.
REQ-009 SHALL have port: TIMEOUT  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE (GNT=0, BUSY=0) and OWN (GNT one-hot, BUSY=1).
REQ-011 SHALL keep internal priority pointer PTR (0..9); after a grant to k, PTR = (k+1) mod 10, with 9 wrapping to 0.
REQ-012 In IDLE with REQ != 0 at edge N, SHALL enter OWN and assert GNT[k] and SEL=k from edge N.
  - k = first set REQ bit scanning PTR, PTR+1, ..., 9, 0, ..., PTR-1.
  - Latency: 1 cycle.
REQ-013 In IDLE with REQ = 0, SHALL remain IDLE; PTR and SEL SHALL be unchanged.
REQ-014 In OWN, GNT and SEL SHALL stay constant; changes on other REQ bits SHALL have no effect.
REQ-015 SHALL keep an 8-bit hold counter.
  - Cleared on grant; value 0 in first OWN cycle.
  - Increments each OWN cycle.
REQ-016 SHALL release (return to IDLE at next edge) when any of these is sampled in an OWN cycle:
  - DONE=1, or
  - REQ[k]=0, or
  - hold counter = MAX_HOLD-1.
  - Maximum grant length is therefore MAX_HOLD cycles.
REQ-017 After release, SHALL spend at least one IDLE cycle with GNT=0 before any new grant (break-before-make).
  - Back-to-back grants are therefore separated by exactly 1 cycle.
REQ-018 SHALL update PTR on release.
REQ-019 SEL SHALL hold the last granted index while IDLE and SHALL never exceed 9.
REQ-020 TIMEOUT SHALL be 1 for exactly the first IDLE cycle after a release caused only by the counter limit.
REQ-021 If DONE=1 or REQ[k]=0 coincides with the counter limit, the release SHALL be a normal release with TIMEOUT=0.
REQ-022 GNT SHALL never have more than one bit set; BUSY SHALL equal OR of GNT.

Reset
REQ-023 With RST=1 at an edge, the block SHALL enter IDLE from that edge regardless of state, including mid-grant.
  - GNT=0, SEL=0, BUSY=0, TIMEOUT=0.
  - PTR=0, hold counter=0.
REQ-024 RST SHALL take priority over REQ and DONE; no grant SHALL be issued in a cycle where RST was sampled high.

Verification
REQ-025 Single requester: after reset, REQ=0x004 held, DONE=1 in 3rd OWN cycle -> GNT=0x004, SEL=2, BUSY=1 for 3 cycles, then GNT=0 and PTR=3.
REQ-026 Full load: REQ=0x3FF held, DONE=1 every OWN cycle.
  - Grants go to 0,1,2,...,9,0 in that order.
  - Each grant lasts 1 cycle, separated by 1 IDLE cycle.
REQ-027 Timeout: MAX_HOLD=16, only REQ[5] held, DONE=0.
  - GNT=0x020 for 16 cycles, then 1 IDLE cycle with TIMEOUT=1.
  - GNT[5] is then re-granted.
REQ-028 Wrap-around: grant 8 completes (PTR=9), then REQ=0x201 -> grant 9, then after gap grant 0.
REQ-029 Reset mid-grant: RST pulsed during grant to 7 -> next cycle GNT=0, SEL=0, BUSY=0; then REQ=0x088 -> grant goes to 3.
REQ-030 Coincident release: DONE=1 in the MAX_HOLD-th OWN cycle -> release with TIMEOUT=0.
